// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the 5-stage RISC-V core's hazard/forwarding logic.
//   forward_mux_code : select code for the Execute-stage operand muxes
//   sb_entry_t       : one scoreboard entry (valid, destination reg, is_load)
//   hazard_state_e   : flush shadow FSM states
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        NO_FORWARD_SELECT = 2'd0,
        EX_RESULT_SELECT  = 2'd1,
        MEM_RESULT_SELECT = 2'd2,
        WB_RESULT_SELECT  = 2'd3
    } forward_mux_code;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } hazard_state_e;

    // Scoreboard stage indices, nearest producer first.
    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    // Forward code granted when the nearest matching producer sits in a stage.
    // A WB-stage producer needs no forward: the register file is write-first.
    localparam forward_mux_code SB_FWD_CODE [SB_DEPTH] = '{
        EX_RESULT_SELECT, WB_RESULT_SELECT, NO_FORWARD_SELECT
    };

    // Stages in which a pending load forces a stall. A load in MEM is picked up
    // by the WB forward path, a load in WB by the write-first register file.
    localparam logic [SB_DEPTH-1:0] SB_LOAD_STALL_MASK = 3'b001;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

endpackage

// File: rtl/hazard_sb_match.sv
// -----------------------------------------------------------------------------
// hazard_sb_match
// Combinational priority match of one source register against the scoreboard.
// Ports:
//   src_addr_i  : source register address
//   src_used_i  : instruction actually reads this source
//   sb_i        : scoreboard entries, index SB_EX (nearest) .. SB_WB (farthest)
//   fwd_code_o  : forward code from the nearest matching producer
//   load_hit_o  : the source depends on a load that is still too far from WB
// -----------------------------------------------------------------------------
module hazard_sb_match
    import core_pkg::*;
(
    input  logic                       [4:0] src_addr_i,
    input  logic                             src_used_i,
    input  sb_entry_t       [SB_DEPTH-1:0]   sb_i,
    output forward_mux_code                  fwd_code_o,
    output logic                             load_hit_o
);

    logic [SB_DEPTH-1:0] hit;
    logic [SB_DEPTH-1:0] is_load;

    // x0 is hard-wired zero, so it never matches any producer.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_stage
            assign hit[gi]     = src_used_i && (src_addr_i != 5'd0) &&
                                 sb_i[gi].valid && (sb_i[gi].rd == src_addr_i);
            assign is_load[gi] = sb_i[gi].is_load;
        end
    endgenerate

    // Walk from the farthest stage to the nearest so the nearest hit wins.
    always_comb begin
        fwd_code_o = NO_FORWARD_SELECT;
        for (int i = SB_DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                fwd_code_o = SB_FWD_CODE[i];
            end
        end
    end

    assign load_hit_o = |(hit & is_load & SB_LOAD_STALL_MASK);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
// Hazard and forwarding controller for the 5-stage RISC-V core. Tracks the
// destination registers in flight (EX, MEM, WB), produces the EX operand
// forward codes, the load-use stall and the wrong-path squash after a redirect.
// Ports:
//   clock, reset           : core clock, synchronous active-high reset
//   id_*                   : register usage of the instruction held in ID
//   ex_flush_ip            : Execute redirected the PC this cycle
//   fa_mux_op / fb_mux_op  : registered forward codes, valid while in EX
//   stall_op               : combinational, hold PC and IF/ID
//   bubble_op              : registered, EX holds a bubble
//   squash_op              : combinational, kill IF/ID contents
//   stall_count_op         : saturating count of stall cycles
//   flush_count_op         : saturating count of ex_flush_ip cycles
// -----------------------------------------------------------------------------
module hazard_forward_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid_ip,
    input  logic [4:0]            id_rs1_addr_ip,
    input  logic [4:0]            id_rs2_addr_ip,
    input  logic                  id_rs1_used_ip,
    input  logic                  id_rs2_used_ip,
    input  logic [4:0]            id_write_reg_addr_ip,
    input  logic                  id_reg_write_ip,
    input  logic                  id_is_load_ip,
    input  logic                  ex_flush_ip,
    output forward_mux_code       fa_mux_op,
    output forward_mux_code       fb_mux_op,
    output logic                  stall_op,
    output logic                  bubble_op,
    output logic                  squash_op,
    output logic [CNT_W-1:0]      stall_count_op,
    output logic [CNT_W-1:0]      flush_count_op
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sb_entry_t        sb_ex_q, sb_ex_d;
    sb_entry_t        sb_mem_q, sb_mem_d;
    sb_entry_t        sb_wb_q, sb_wb_d;
    hazard_state_e    state_q, state_d;
    forward_mux_code  fa_q, fa_d;
    forward_mux_code  fb_q, fb_d;
    logic             bubble_q, bubble_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    sb_entry_t [SB_DEPTH-1:0] sb_vec;
    forward_mux_code          rs1_code;
    forward_mux_code          rs2_code;
    logic                     rs1_load_hit;
    logic                     rs2_load_hit;
    logic                     id_issue;

    assign sb_vec[SB_EX]  = sb_ex_q;
    assign sb_vec[SB_MEM] = sb_mem_q;
    assign sb_vec[SB_WB]  = sb_wb_q;

    hazard_sb_match u_match_rs1 (
        .src_addr_i (id_rs1_addr_ip),
        .src_used_i (id_rs1_used_ip),
        .sb_i       (sb_vec),
        .fwd_code_o (rs1_code),
        .load_hit_o (rs1_load_hit)
    );

    hazard_sb_match u_match_rs2 (
        .src_addr_i (id_rs2_addr_ip),
        .src_used_i (id_rs2_used_ip),
        .sb_i       (sb_vec),
        .fwd_code_o (rs2_code),
        .load_hit_o (rs2_load_hit)
    );

    // Both zero-latency controls are gated by reset so a reset asserted
    // mid-stall or mid-shadow takes effect in the same cycle. Squash wins
    // over stall: a killed instruction has nothing to wait for.
    assign squash_op = !reset && (ex_flush_ip || (state_q == SHADOW));
    assign stall_op  = !reset && !squash_op && id_valid_ip &&
                       (rs1_load_hit || rs2_load_hit);

    // The ID instruction advances into EX only when neither held nor killed.
    assign id_issue  = id_valid_ip && !stall_op && !squash_op;

    always_comb begin
        sb_wb_d  = sb_mem_q;
        sb_mem_d = sb_ex_q;
        sb_ex_d  = SB_EMPTY;
        if (id_issue && id_reg_write_ip && (id_write_reg_addr_ip != 5'd0)) begin
            sb_ex_d.valid   = 1'b1;
            sb_ex_d.rd      = id_write_reg_addr_ip;
            sb_ex_d.is_load = id_is_load_ip;
        end

        fa_d     = id_issue ? rs1_code : NO_FORWARD_SELECT;
        fb_d     = id_issue ? rs2_code : NO_FORWARD_SELECT;
        bubble_d = stall_op || squash_op;

        // RUN enters SHADOW on a redirect; SHADOW stays while redirects keep
        // arriving, since each one leaves another wrong-path fetch behind.
        state_d = state_q;
        case (state_q)
            RUN:     state_d = ex_flush_ip ? SHADOW : RUN;
            SHADOW:  state_d = ex_flush_ip ? SHADOW : RUN;
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_op && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_flush_ip && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_ex_q     <= SB_EMPTY;
            sb_mem_q    <= SB_EMPTY;
            sb_wb_q     <= SB_EMPTY;
            state_q     <= RUN;
            fa_q        <= NO_FORWARD_SELECT;
            fb_q        <= NO_FORWARD_SELECT;
            bubble_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            state_q     <= state_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            bubble_q    <= bubble_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fa_mux_op      = fa_q;
    assign fb_mux_op      = fb_q;
    assign bubble_op      = bubble_q;
    assign stall_count_op = stall_cnt_q;
    assign flush_count_op = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;
    import core_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            id_valid_ip;
    logic [4:0]      id_rs1_addr_ip;
    logic [4:0]      id_rs2_addr_ip;
    logic            id_rs1_used_ip;
    logic            id_rs2_used_ip;
    logic [4:0]      id_write_reg_addr_ip;
    logic            id_reg_write_ip;
    logic            id_is_load_ip;
    logic            ex_flush_ip;
    forward_mux_code fa_mux_op;
    forward_mux_code fb_mux_op;
    logic            stall_op;
    logic            bubble_op;
    logic            squash_op;
    logic [31:0]     stall_count_op;
    logic [31:0]     flush_count_op;

    int test_cnt = 0;
    int fail_cnt = 0;

    always #5 clock = ~clock;

    hazard_forward_ctrl #(.CNT_W(32)) dut (
        .clock                (clock),
        .reset                (reset),
        .id_valid_ip          (id_valid_ip),
        .id_rs1_addr_ip       (id_rs1_addr_ip),
        .id_rs2_addr_ip       (id_rs2_addr_ip),
        .id_rs1_used_ip       (id_rs1_used_ip),
        .id_rs2_used_ip       (id_rs2_used_ip),
        .id_write_reg_addr_ip (id_write_reg_addr_ip),
        .id_reg_write_ip      (id_reg_write_ip),
        .id_is_load_ip        (id_is_load_ip),
        .ex_flush_ip          (ex_flush_ip),
        .fa_mux_op            (fa_mux_op),
        .fb_mux_op            (fb_mux_op),
        .stall_op             (stall_op),
        .bubble_op            (bubble_op),
        .squash_op            (squash_op),
        .stall_count_op       (stall_count_op),
        .flush_count_op       (flush_count_op)
    );

    // Present an ID instruction (and flush) and let combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic fl);
        id_valid_ip          = v;
        id_rs1_addr_ip       = rs1;
        id_rs1_used_ip       = u1;
        id_rs2_addr_ip       = rs2;
        id_rs2_used_ip       = u2;
        id_write_reg_addr_ip = rd;
        id_reg_write_ip      = rw;
        id_is_load_ip        = ld;
        ex_flush_ip          = fl;
        #1;
    endtask

    // One clock edge; prints one line for the transaction just clocked.
    task automatic tick();
        @(posedge clock);
        #1;
        $display("[TB] t=%0t id v=%0b rs1=x%0d rs2=x%0d rd=x%0d we=%0b ld=%0b fl=%0b rst=%0b -> fa=%0d fb=%0d bubble=%0b",
                 $time, id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_write_reg_addr_ip,
                 id_reg_write_ip, id_is_load_ip, ex_flush_ip, reset, fa_mux_op, fb_mux_op, bubble_op);
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL reset_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL reset_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL reset_bubble got=%0b want=0", bubble_op); end
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL reset_stall got=%0b want=0", stall_op); end
        test_cnt++; if (squash_op !== 1'b0) begin fail_cnt++; $display("FAIL reset_squash got=%0b want=0", squash_op); end
        test_cnt++; if (stall_count_op !== 32'd0) begin fail_cnt++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_count_op); end
        test_cnt++; if (flush_count_op !== 32'd0) begin fail_cnt++; $display("FAIL reset_flush_cnt got=%0d want=0", flush_count_op); end
        reset = 1'b0;
        tick();
    endtask

    // add x5,x1,x2 ; add x6,x5,x1 back to back
    task automatic test_ex_forward();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL exfwd_prod_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL exfwd_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== EX_RESULT_SELECT) begin fail_cnt++; $display("FAIL exfwd_fa got=%0d want=%0d", fa_mux_op, EX_RESULT_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL exfwd_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL exfwd_bubble got=%0b want=0", bubble_op); end
        drain();
    endtask

    // producer x5, unrelated, reader rs2=x5 (WB forward), then reader x5 (write-first)
    task automatic test_wb_forward();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        tick();
        drive(1, 5'd10, 1, 5'd11, 1, 5'd9, 1, 0, 0);
        tick();
        drive(1, 5'd12, 1, 5'd5, 1, 5'd0, 0, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL wbfwd_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fb_mux_op !== WB_RESULT_SELECT) begin fail_cnt++; $display("FAIL wbfwd_fb got=%0d want=%0d", fb_mux_op, WB_RESULT_SELECT); end
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL wbfwd_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL wbstage_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        drain();
    endtask

    // lw x7 ; add x8,x7,x7
    task automatic test_load_use();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        tick();
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL ld_first_bubble got=%0b want=0", bubble_op); end
        drive(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        test_cnt++; if (stall_op !== 1'b1) begin fail_cnt++; $display("FAIL ld_stall got=%0b want=1", stall_op); end
        test_cnt++; if (squash_op !== 1'b0) begin fail_cnt++; $display("FAIL ld_squash got=%0b want=0", squash_op); end
        tick();
        test_cnt++; if (bubble_op !== 1'b1) begin fail_cnt++; $display("FAIL ld_bubble got=%0b want=1", bubble_op); end
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL ld_bubble_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL ld_bubble_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL ld_stall_once got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== WB_RESULT_SELECT) begin fail_cnt++; $display("FAIL ld_fa got=%0d want=%0d", fa_mux_op, WB_RESULT_SELECT); end
        test_cnt++; if (fb_mux_op !== WB_RESULT_SELECT) begin fail_cnt++; $display("FAIL ld_fb got=%0d want=%0d", fb_mux_op, WB_RESULT_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL ld_after_bubble got=%0b want=0", bubble_op); end
        test_cnt++; if (stall_count_op !== 32'd1) begin fail_cnt++; $display("FAIL ld_stall_cnt got=%0d want=1", stall_count_op); end
        drain();
    endtask

    // addi x0 ; reader x0 ; lw x0 ; reader x0
    task automatic test_x0();
        drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        tick();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL x0_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL x0_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL x0_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        drive(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0);
        tick();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL x0_load_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL x0_load_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        drain();
    endtask

    // lw x3 ; invalid slot naming x3 ; real reader of x3
    task automatic test_idle();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1, 0);
        tick();
        drive(0, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL idle_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL idle_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL idle_bubble got=%0b want=0", bubble_op); end
        drive(1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 0, 0);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL idle_rd_stall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== WB_RESULT_SELECT) begin fail_cnt++; $display("FAIL idle_rd_fa got=%0d want=%0d", fa_mux_op, WB_RESULT_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL idle_rd_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        drain();
    endtask

    // One-cycle flush: squash two cycles, squashed writers x4/x13 never forward
    task automatic test_flush();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 1);
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL fl_squash0 got=%0b want=1", squash_op); end
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL fl_stall0 got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (bubble_op !== 1'b1) begin fail_cnt++; $display("FAIL fl_bubble0 got=%0b want=1", bubble_op); end
        drive(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 0, 0);
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL fl_squash1 got=%0b want=1", squash_op); end
        tick();
        test_cnt++; if (bubble_op !== 1'b1) begin fail_cnt++; $display("FAIL fl_bubble1 got=%0b want=1", bubble_op); end
        drive(1, 5'd4, 1, 5'd13, 1, 5'd0, 0, 0, 0);
        test_cnt++; if (squash_op !== 1'b0) begin fail_cnt++; $display("FAIL fl_squash2 got=%0b want=0", squash_op); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL fl_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL fl_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL fl_bubble2 got=%0b want=0", bubble_op); end
        test_cnt++; if (flush_count_op !== 32'd1) begin fail_cnt++; $display("FAIL fl_cnt got=%0d want=1", flush_count_op); end
        drain();
    endtask

    // Flush arriving together with a load-use hazard: squash wins
    task automatic test_flush_over_stall();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        tick();
        drive(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 1);
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL fs_stall got=%0b want=0", stall_op); end
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL fs_squash got=%0b want=1", squash_op); end
        tick();
        drive(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0);
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL fs_shadow got=%0b want=1", squash_op); end
        tick();
        test_cnt++; if (squash_op !== 1'b0) begin fail_cnt++; $display("FAIL fs_run got=%0b want=0", squash_op); end
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL fs_nostall got=%0b want=0", stall_op); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL fs_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (stall_count_op !== 32'd1) begin fail_cnt++; $display("FAIL fs_stall_cnt got=%0d want=1", stall_count_op); end
        test_cnt++; if (flush_count_op !== 32'd2) begin fail_cnt++; $display("FAIL fs_flush_cnt got=%0d want=2", flush_count_op); end
        drain();
    endtask

    // Two consecutive flushes keep the shadow open one cycle past the last one
    task automatic test_back_to_back();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL b2b_squash1 got=%0b want=1", squash_op); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_cnt++; if (squash_op !== 1'b1) begin fail_cnt++; $display("FAIL b2b_shadow got=%0b want=1", squash_op); end
        tick();
        test_cnt++; if (bubble_op !== 1'b1) begin fail_cnt++; $display("FAIL b2b_bubble got=%0b want=1", bubble_op); end
        test_cnt++; if (squash_op !== 1'b0) begin fail_cnt++; $display("FAIL b2b_run got=%0b want=0", squash_op); end
        tick();
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL b2b_bubble_end got=%0b want=0", bubble_op); end
        test_cnt++; if (flush_count_op !== 32'd4) begin fail_cnt++; $display("FAIL b2b_flush_cnt got=%0d want=4", flush_count_op); end
    endtask

    // Reset asserted in the middle of a load-use stall
    task automatic test_reset_mid_stall();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        tick();
        drive(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        test_cnt++; if (stall_op !== 1'b1) begin fail_cnt++; $display("FAIL rms_pre_stall got=%0b want=1", stall_op); end
        reset = 1'b1;
        #1;
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL rms_in_reset_stall got=%0b want=0", stall_op); end
        tick();
        reset = 1'b0;
        #1;
        test_cnt++; if (stall_op !== 1'b0) begin fail_cnt++; $display("FAIL rms_post_stall got=%0b want=0", stall_op); end
        test_cnt++; if (stall_count_op !== 32'd0) begin fail_cnt++; $display("FAIL rms_stall_cnt got=%0d want=0", stall_count_op); end
        test_cnt++; if (flush_count_op !== 32'd0) begin fail_cnt++; $display("FAIL rms_flush_cnt got=%0d want=0", flush_count_op); end
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL rms_fa_reset got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        tick();
        test_cnt++; if (fa_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL rms_fa got=%0d want=%0d", fa_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (fb_mux_op !== NO_FORWARD_SELECT) begin fail_cnt++; $display("FAIL rms_fb got=%0d want=%0d", fb_mux_op, NO_FORWARD_SELECT); end
        test_cnt++; if (bubble_op !== 1'b0) begin fail_cnt++; $display("FAIL rms_bubble got=%0b want=0", bubble_op); end
        drain();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_x0();
        test_idle();
        test_flush();
        test_flush_over_stall();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

- Hazard and forwarding controller for the 5-stage RISCV core.
- Consumes the ID-stage instruction's register usage and the Execute-stage flush request.
- Keeps a shadow scoreboard of destination registers in flight (EX, MEM, WB).
- Produces the forward-A/forward-B mux codes the Execute stage consumes, plus the load-use stall, bubble and wrong-path squash controls for Fetch/Decode.

## Interface
- CNT_W, 32, width of the stall and flush performance counters
- clock  in  1  core clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- id_valid_ip  in  1  ID holds a real instruction
- id_rs1_addr_ip / id_rs2_addr_ip  in  5 each  ID source registers
- id_rs1_used_ip / id_rs2_used_ip  in  1 each  instruction reads rs1 / rs2
- id_write_reg_addr_ip  in  5  ID destination register
- id_reg_write_ip  in  1  instruction writes the register file
- id_is_load_ip  in  1  instruction is a load (result available only at WB)
- ex_flush_ip  in  1  Execute redirected the PC this cycle
- fa_mux_op / fb_mux_op  out  forward_mux_code  registered; valid while the instruction is in EX
- stall_op  out  1  combinational; hold PC and IF/ID this cycle
- bubble_op  out  1  registered; EX holds a bubble (ALU/LSU enables must be forced low)
- squash_op  out  1  combinational; kill IF/ID contents this cycle
- stall_count_op / flush_count_op  out  CNT_W  saturating event counters

## Operation
- Scoreboard: three entries SB_EX, SB_MEM, SB_WB. Each entry holds valid, rd[4:0], is_load.
- Every cycle: SB_WB<=SB_MEM, SB_MEM<=SB_EX.
- SB_EX<=ID entry only if id_valid_ip & id_reg_write_ip & rd!=0 & !stall_op & !squash_op. Otherwise SB_EX is invalid.
- Match for source s: s_used & s!=0 & entry.valid & entry.rd==s.
- Forward code for each source is computed from the ID instruction and registered. Nearest producer wins:
  - SB_EX match -> EX_RESULT_SELECT (producer sits in EX/MEM register next cycle)
  - else SB_MEM match -> WB_RESULT_SELECT (producer is at writeback next cycle)
  - else NO_FORWARD_SELECT. The register file is write-first, so an SB_WB match needs no forward.
- MEM_RESULT_SELECT is never emitted.
- Load-use: an SB_EX match with SB_EX.is_load on any used source raises stall_op=1 for exactly one cycle.
  - That cycle SB_EX<=invalid, bubble_op<=1, and fa/fb<=NO_FORWARD_SELECT.
  - Next cycle the load is in SB_MEM, the bubble sits in SB_EX, and the code resolves to WB_RESULT_SELECT.
- FSM states RUN, SHADOW:
  - RUN: ex_flush_ip -> squash_op=1 (kills the ID instruction), bubble_op<=1, go to SHADOW.
  - SHADOW: squash_op=1 again (kills the instruction fetched on the wrong path), bubble_op<=1.
    - With ex_flush_ip=0 -> RUN.
    - A new ex_flush_ip stays in SHADOW.
- Priority: squash over stall. stall_op=0 whenever squash_op=1.
- Counters: stall_count_op +1 per stall cycle; flush_count_op +1 per ex_flush_ip cycle. Both hold at all-ones.

## Timing
- Reset state:
  - FSM=RUN, all scoreboard entries invalid.
  - fa_mux_op=fb_mux_op=NO_FORWARD_SELECT, bubble_op=0, stall_op=0, squash_op=0.
  - Counters=0.
- Reset mid-stall or mid-SHADOW aborts that state immediately; the next cycle behaves as post-reset.
- Forward codes and bubble_op have 1-cycle latency: computed while the instruction is in ID, used while it is in EX.
- stall_op and squash_op are zero-latency, same cycle as the condition.
- id_valid_ip=0 produces NO_FORWARD_SELECT and no scoreboard entry. It never stalls.
- rs1==rs2 matching a load: a single one-cycle stall, and both codes resolve identically.
- x0 is never matched, never stalled on, never forwarded.

## Structure
- forward_mux_code, including NO_FORWARD_SELECT, lives in CORE_PKG.
- New in CORE_PKG: sb_entry_t struct (valid, rd, is_load) and hazard_state_e (RUN, SHADOW).
- One sub-module, hazard_sb_match: combinational priority match of one source register against three entries, returning forward_mux_code and a load-hit flag. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- add x5 then add x6,x5,x1 back-to-back -> fa_mux_op=EX_RESULT_SELECT in the consumer's EX cycle; no stall.
- Producer x5, one unrelated instruction, then consumer rs2=x5 -> fb_mux_op=WB_RESULT_SELECT.
- lw x7 then add x8,x7,x7:
  - stall_op=1 for one cycle, then bubble_op=1.
  - Then fa=fb=WB_RESULT_SELECT; stall_count_op=1.
- addi x0,... followed by a reader of x0 -> codes NO_FORWARD_SELECT, no stall.
- ex_flush_ip pulse for one cycle:
  - squash_op=1 for two cycles and bubble_op=1 for two EX cycles.
  - Squashed writers never forward; flush_count_op=1.
- Assert reset during a load-use stall -> next cycle stall_op=0, codes NO_FORWARD_SELECT, counters 0.
